// File: rtl/pipe_skid_stage.sv
// Pipeline register stage with an optional two-entry skid buffer, flush, and
// one-shot control bits that are visible only on the first cycle an entry is head.
module pipe_skid_stage #(
    parameter int                DATA_W       = 32,
    parameter int                CTRL_W       = 8,
    parameter logic [CTRL_W-1:0] ONESHOT_MASK = '0,
    parameter bit                SKID_EN      = 1'b1
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic              i_flush,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [DATA_W-1:0] i_data,
    input  logic [CTRL_W-1:0] i_ctrl,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [DATA_W-1:0] o_data,
    output logic [CTRL_W-1:0] o_ctrl,
    output logic [1:0]        o_count
);

    // State encoding doubles as the occupancy count.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [DATA_W-1:0] main_data;
    logic [DATA_W-1:0] skid_data;
    logic [CTRL_W-1:0] main_ctrl;
    logic [CTRL_W-1:0] skid_ctrl;

    logic fresh;
    logic fresh_next;
    logic ready_q;
    logic accept;
    logic retire;
    logic load_main_in;
    logic load_main_skid;
    logic load_skid;

    assign o_valid = (state != EMPTY);
    assign o_ready = SKID_EN ? ready_q : i_ready;
    assign accept  = i_valid & o_ready;
    assign retire  = o_valid & i_ready;
    assign o_data  = main_data;
    assign o_count = state;
    assign o_ctrl  = !o_valid ? '0 : (fresh ? main_ctrl : (main_ctrl & ~ONESHOT_MASK));

    always_comb begin
        state_next     = state;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        if (i_flush) begin
            state_next = EMPTY;
        end else if (SKID_EN) begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        load_main_in = 1'b1;
                        state_next   = ONE;
                    end
                end
                ONE: begin
                    if (accept && retire) begin
                        load_main_in = 1'b1;
                    end else if (accept) begin
                        load_skid  = 1'b1;
                        state_next = FULL;
                    end else if (retire) begin
                        state_next = EMPTY;
                    end
                end
                FULL: begin
                    // Upstream is stalled here, so only a retire can move things.
                    if (retire) begin
                        load_main_skid = 1'b1;
                        state_next     = ONE;
                    end
                end
                default: state_next = EMPTY;
            endcase
        end else begin
            // Legacy pipeline register: loads whenever downstream advances.
            if (i_ready) begin
                load_main_in = 1'b1;
                state_next   = i_valid ? ONE : EMPTY;
            end
        end
        fresh_next = load_main_in | load_main_skid;
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state   <= EMPTY;
            fresh   <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            state   <= state_next;
            fresh   <= fresh_next;
            ready_q <= (state_next != FULL);
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            main_data <= '0;
            main_ctrl <= '0;
            skid_data <= '0;
            skid_ctrl <= '0;
        end else begin
            if (load_main_in) begin
                main_data <= i_data;
                main_ctrl <= i_ctrl;
            end else if (load_main_skid) begin
                main_data <= skid_data;
                main_ctrl <= skid_ctrl;
            end
            if (load_skid) begin
                skid_data <= i_data;
                skid_ctrl <= i_ctrl;
            end
        end
    end

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Directed bench for pipe_skid_stage: one skid instance and one legacy instance,
// both with one-shot mask 8'h02, checked against hand-computed values.
module tb_pipe_skid_stage;

    logic        clk;
    // skid instance
    logic        reset_n;
    logic        flush;
    logic        valid;
    logic        ready_out;
    logic [31:0] data;
    logic [7:0]  ctrl;
    logic        valid_out;
    logic        ready;
    logic [31:0] data_out;
    logic [7:0]  ctrl_out;
    logic [1:0]  count_out;
    // legacy instance
    logic        l_reset_n;
    logic        l_flush;
    logic        l_valid;
    logic        l_ready_out;
    logic [31:0] l_data;
    logic [7:0]  l_ctrl;
    logic        l_valid_out;
    logic        l_ready;
    logic [31:0] l_data_out;
    logic [7:0]  l_ctrl_out;
    logic [1:0]  l_count_out;

    int vectors;
    int errors;

    pipe_skid_stage #(.DATA_W(32), .CTRL_W(8), .ONESHOT_MASK(8'h02), .SKID_EN(1'b1)) dut (
        .i_clk(clk), .i_reset_n(reset_n), .i_flush(flush), .i_valid(valid),
        .o_ready(ready_out), .i_data(data), .i_ctrl(ctrl), .o_valid(valid_out),
        .i_ready(ready), .o_data(data_out), .o_ctrl(ctrl_out), .o_count(count_out)
    );

    pipe_skid_stage #(.DATA_W(32), .CTRL_W(8), .ONESHOT_MASK(8'h02), .SKID_EN(1'b0)) dut_legacy (
        .i_clk(clk), .i_reset_n(l_reset_n), .i_flush(l_flush), .i_valid(l_valid),
        .o_ready(l_ready_out), .i_data(l_data), .i_ctrl(l_ctrl), .o_valid(l_valid_out),
        .i_ready(l_ready), .o_data(l_data_out), .o_ctrl(l_ctrl_out), .o_count(l_count_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    // Drive the skid instance for one clock, then settle just after the edge.
    task automatic applyStimulus(input logic v, input logic [31:0] d, input logic [7:0] c,
                                 input logic rdy, input logic fl);
        valid = v;
        data  = d;
        ctrl  = c;
        ready = rdy;
        flush = fl;
        @(posedge clk);
        #1;
    endtask

    task automatic checkSkid(input string tag, input logic v, input logic [31:0] d,
                             input logic [7:0] c, input logic [1:0] n, input logic r);
        checkOutput({tag, ".valid"}, 32'(valid_out), 32'(v));
        if (v) checkOutput({tag, ".data"}, data_out, d);
        checkOutput({tag, ".ctrl"}, 32'(ctrl_out), 32'(c));
        checkOutput({tag, ".count"}, 32'(count_out), 32'(n));
        checkOutput({tag, ".ready"}, 32'(ready_out), 32'(r));
    endtask

    initial begin
        vectors = 0;
        errors  = 0;
        reset_n = 1'b0;
        flush = 1'b0; valid = 1'b0; data = '0; ctrl = '0; ready = 1'b0;
        l_reset_n = 1'b0;
        l_flush = 1'b0; l_valid = 1'b0; l_data = '0; l_ctrl = '0; l_ready = 1'b0;

        applyStimulus(1'b1, 32'hDEAD, 8'hFF, 1'b1, 1'b0);
        applyStimulus(1'b1, 32'hDEAD, 8'hFF, 1'b1, 1'b0);
        checkSkid("reset", 1'b0, 32'h0, 8'h00, 2'd0, 1'b1);
        checkOutput("reset.data0", data_out, 32'h0);
        reset_n = 1'b1;

        // streaming 1..8 with no backpressure
        for (int i = 1; i <= 8; i++) begin
            applyStimulus(1'b1, 32'(i), 8'h00, 1'b1, 1'b0);
            checkSkid($sformatf("stream%0d", i), 1'b1, 32'(i), 8'h00, 2'd1, 1'b1);
        end
        applyStimulus(1'b0, 32'h0, 8'h00, 1'b1, 1'b0);
        checkSkid("drain", 1'b0, 32'h0, 8'h00, 2'd0, 1'b1);

        // backpressure into skid then release
        applyStimulus(1'b1, 32'hA, 8'h00, 1'b1, 1'b0);
        checkSkid("bp.headA", 1'b1, 32'hA, 8'h00, 2'd1, 1'b1);
        applyStimulus(1'b1, 32'hB, 8'h00, 1'b0, 1'b0);
        checkSkid("bp.full", 1'b1, 32'hA, 8'h00, 2'd2, 1'b0);
        applyStimulus(1'b1, 32'hBAD, 8'h00, 1'b0, 1'b0);
        checkSkid("bp.ignored", 1'b1, 32'hA, 8'h00, 2'd2, 1'b0);
        applyStimulus(1'b0, 32'h0, 8'h00, 1'b1, 1'b0);
        checkSkid("bp.headB", 1'b1, 32'hB, 8'h00, 2'd1, 1'b1);
        applyStimulus(1'b0, 32'h0, 8'h00, 1'b1, 1'b0);
        checkSkid("bp.empty", 1'b0, 32'h0, 8'h00, 2'd0, 1'b1);

        // one-shot: 03,01,01 while held; promoted skid entry shows 02 once
        applyStimulus(1'b1, 32'hC, 8'h03, 1'b0, 1'b0);
        checkSkid("os.first", 1'b1, 32'hC, 8'h03, 2'd1, 1'b1);
        applyStimulus(1'b1, 32'hD, 8'h02, 1'b0, 1'b0);
        checkSkid("os.held1", 1'b1, 32'hC, 8'h01, 2'd2, 1'b0);
        applyStimulus(1'b0, 32'h0, 8'h00, 1'b0, 1'b0);
        checkSkid("os.held2", 1'b1, 32'hC, 8'h01, 2'd2, 1'b0);
        applyStimulus(1'b0, 32'h0, 8'h00, 1'b1, 1'b0);
        checkSkid("os.promote", 1'b1, 32'hD, 8'h02, 2'd1, 1'b1);
        applyStimulus(1'b0, 32'h0, 8'h00, 1'b0, 1'b0);
        checkSkid("os.masked", 1'b1, 32'hD, 8'h00, 2'd1, 1'b1);

        // flush from FULL with a live input that must vanish
        applyStimulus(1'b1, 32'hE, 8'h10, 1'b0, 1'b0);
        checkSkid("fl.full", 1'b1, 32'hD, 8'h00, 2'd2, 1'b0);
        applyStimulus(1'b1, 32'h55, 8'hFF, 1'b0, 1'b1);
        checkSkid("fl.flushed", 1'b0, 32'h0, 8'h00, 2'd0, 1'b1);
        checkOutput("fl.data_kept", data_out, 32'hD);
        applyStimulus(1'b0, 32'h0, 8'h00, 1'b1, 1'b0);
        checkSkid("fl.after", 1'b0, 32'h0, 8'h00, 2'd0, 1'b1);
        checkOutput("fl.no55", data_out, 32'hD);

        // reset while FULL, then immediate accept
        applyStimulus(1'b1, 32'h1, 8'h00, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h2, 8'h00, 1'b0, 1'b0);
        checkSkid("rst.full", 1'b1, 32'h1, 8'h00, 2'd2, 1'b0);
        reset_n = 1'b0;
        applyStimulus(1'b1, 32'h3, 8'h03, 1'b1, 1'b1);
        checkSkid("rst.mid", 1'b0, 32'h0, 8'h00, 2'd0, 1'b1);
        checkOutput("rst.data0", data_out, 32'h0);
        reset_n = 1'b1;
        applyStimulus(1'b1, 32'h77, 8'h01, 1'b0, 1'b0);
        checkSkid("rst.accept", 1'b1, 32'h77, 8'h01, 2'd1, 1'b1);

        // legacy single-register mode
        @(posedge clk);
        #1;
        checkOutput("leg.reset.valid", 32'(l_valid_out), 32'd0);
        checkOutput("leg.reset.count", 32'(l_count_out), 32'd0);
        l_reset_n = 1'b1;
        l_valid = 1'b1; l_data = 32'h11; l_ctrl = 8'h03; l_ready = 1'b1;
        #1;
        checkOutput("leg.ready_hi", 32'(l_ready_out), 32'd1);
        @(posedge clk);
        #1;
        checkOutput("leg.load.data", l_data_out, 32'h11);
        checkOutput("leg.load.ctrl", 32'(l_ctrl_out), 32'h03);
        checkOutput("leg.load.count", 32'(l_count_out), 32'd1);
        l_data = 32'h22; l_ready = 1'b0;
        #1;
        checkOutput("leg.ready_lo", 32'(l_ready_out), 32'd0);
        @(posedge clk);
        #1;
        checkOutput("leg.hold.data", l_data_out, 32'h11);
        checkOutput("leg.hold.ctrl", 32'(l_ctrl_out), 32'h01);
        checkOutput("leg.hold.valid", 32'(l_valid_out), 32'd1);
        l_ready = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("leg.next.data", l_data_out, 32'h22);
        checkOutput("leg.next.ctrl", 32'(l_ctrl_out), 32'h03);
        l_valid = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("leg.empty.valid", 32'(l_valid_out), 32'd0);
        checkOutput("leg.empty.ctrl", 32'(l_ctrl_out), 32'd0);
        checkOutput("leg.empty.count", 32'(l_count_out), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/pipe_skid_stage.md
PIPE_SKID_STAGE -- requirements
Module: pipe_skid_stage

Interface
REQ-001 SHALL have parameter DATA_W, default 32: payload width (pc, alu result, store data, imm, ...), not cleared on flush.
REQ-002 SHALL have parameter CTRL_W, default 8: control width (regwrite, memread, memwrite, wb_sel, ...), cleared on flush.
REQ-003 SHALL have parameter ONESHOT_MASK [CTRL_W-1:0], default 0: control bits asserted only on the first cycle an entry is presented.
REQ-004 SHALL have parameter SKID_EN, default 1: 1 = two-entry skid stage with registered o_ready; 0 = single register with legacy stall semantics.
REQ-005 i_clk  in  1  single clock, rising edge.
REQ-006 i_reset_n  in  1  synchronous, active-low reset.
REQ-007 i_flush  in  1  kill all held entries.
REQ-008 i_valid  in  1  upstream entry valid.
REQ-009 o_ready  out  1  stage can accept this cycle.
REQ-010 i_data  in  DATA_W  upstream payload.
REQ-011 i_ctrl  in  CTRL_W  upstream control.
REQ-012 o_valid  out  1  head entry valid.
REQ-013 i_ready  in  1  downstream accepts head this cycle.
REQ-014 o_data  out  DATA_W  head payload.
REQ-015 o_ctrl  out  CTRL_W  head control, one-shot bits masked as per REQ-023.
REQ-016 o_count  out  2  entries held (0..2).

Function
REQ-017 Accept = i_valid & o_ready; retire = o_valid & i_ready; both SHALL be evaluated on the same edge.
REQ-018 Latency SHALL be 1 cycle: an entry accepted at edge N appears on o_valid/o_data/o_ctrl after edge N when the stage was empty or the head retired at edge N.
REQ-019 SKID_EN=1: states EMPTY (count 0), ONE (main valid), FULL (main + skid valid); o_ready SHALL be registered and equal to (state != FULL).
REQ-020 Transitions: EMPTY+accept->ONE; ONE+accept&!retire->FULL (entry into skid); ONE+retire&!accept->EMPTY; ONE+accept&retire->ONE (main replaced); FULL+retire->ONE (skid moves to main in same edge); FULL otherwise holds.
REQ-021 Ordering SHALL be strict FIFO; no entry dropped or duplicated; throughput 1 entry/cycle when i_ready stays high.
REQ-022 SKID_EN=0: o_ready SHALL equal i_ready (combinational); head loads when i_ready=1, holds otherwise; o_count is 0 or 1.
REQ-023 One-shot: bits in ONESHOT_MASK SHALL be driven from the stored value only in the first cycle an entry is head; while the same entry is held (o_valid & !i_ready), those bits SHALL read 0 from the next cycle on.
REQ-024 An entry promoted from skid to main SHALL count as newly presented (one-shot bits visible for one cycle).
REQ-025 i_flush SHALL take priority over accept and retire: next state EMPTY, o_valid=0, o_ctrl=0, o_count=0, o_ready=1; o_data retains its previous value.
REQ-026 Input presented on a flush cycle SHALL be discarded even if i_valid=1.
REQ-027 When o_valid=0, o_ctrl SHALL be 0 regardless of stored contents.
REQ-028 i_valid while o_ready=0 SHALL be ignored; upstream holds per handshake.

Reset
REQ-029 i_reset_n=0 at an edge SHALL force o_valid=0, o_data=0, o_ctrl=0, o_count=0, o_ready=1, overriding flush and handshakes, including mid-transfer with FULL state.
REQ-030 The first accept SHALL be possible on the first edge after i_reset_n returns high.

Verification
REQ-031 Streaming: SKID_EN=1, i_ready=1, i_valid=1 for 8 cycles, data 1..8 -> o_data 1..8 on consecutive cycles one cycle later, o_count stays 1, o_ready stays 1.
REQ-032 Backpressure: head=0xA, i_ready=0, accept 0xB -> o_count=2, o_ready=0 next cycle; i_ready=1 -> 0xA retires, 0xB head, then o_ready=1.
REQ-033 One-shot: ONESHOT_MASK=8'h02, entry ctrl=8'h03, i_ready=0 for 3 cycles -> o_ctrl 03, 01, 01; after promotion from skid, ctrl 8'h02 shows 02 for one cycle.
REQ-034 Flush in FULL with i_valid=1, i_data=0x55 -> next cycle o_valid=0, o_ctrl=0, o_count=0, o_ready=1, 0x55 never appears.
REQ-035 Reset mid-operation in FULL -> o_valid=0, o_data=0, o_ctrl=0, o_count=0, o_ready=1; accept on the next edge works.
REQ-036 SKID_EN=0: i_ready=0 with i_valid=1 -> o_ready=0 same cycle, head held, memread-masked bit cleared after first cycle.
